// File: rtl/sobol_sng_ctrl.sv
// sobol_sng_ctrl: dimension-1 Sobol stochastic bitstream sequencer.
// Define SNG_ONES_CNT_EN to add the onesCnt port and its counter.
module sobol_sng_ctrl #(
  parameter int INWD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [INWD-1:0] operand,
  input  logic            hold,
  input  logic            abort,
  output logic            busy,
  output logic            bitValid,
  output logic            bitOut,
  output logic [INWD-1:0] randOut,
`ifdef SNG_ONES_CNT_EN
  output logic [INWD:0]   onesCnt,
`endif
  output logic            last
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [INWD-1:0] DIR0 =
    {1'b1, {(INWD-1){1'b0}}};

  state_t          state;
  state_t          state_nx;
  logic [INWD-1:0] cnt;
  logic [INWD-1:0] seq;
  logic [INWD-1:0] op;
  logic [INWD-1:0] lsz_hot;
  logic [INWD-1:0] dir;
  logic            fin;
  logic            acc;
  logic            chain;
  logic            emit;
  logic            emit0;

  // The final bit of a stream is on the outputs this cycle.
  assign fin   = bitValid & last;
  assign busy  = (state == RUN);
  assign emit0 = chain & ~hold;

  // One-hot least-significant zero of cnt, bit-reversed into dirVec[k].
  always_comb begin
    lsz_hot = ~cnt & (cnt + INWD'(1));
    dir     = '0;
    for (int i = 0; i < INWD; i++) begin
      dir[i] = lsz_hot[INWD-1-i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: abort beats chaining; a finished stream without start idles.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (fin && !start) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control strobes: accept, chained accept and per-bit emission.
  always_comb begin
    acc   = 1'b0;
    chain = 1'b0;
    emit  = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        acc = start;
      end
      (state == RUN): begin
        chain = !abort && fin && start;
        acc   = chain;
        emit  = !abort && !fin && !hold;
      end
      default: ;
    endcase
  end

  // Generator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op       <= '0;
      cnt      <= '0;
      seq      <= '0;
      bitValid <= 1'b0;
      bitOut   <= 1'b0;
      randOut  <= '0;
      last     <= 1'b0;
    end else if (emit0) begin
      // Chained start emits bit 0 at once so streams abut.
      op       <= operand;
      cnt      <= INWD'(1);
      seq      <= DIR0;
      bitValid <= 1'b1;
      randOut  <= '0;
      bitOut   <= (operand != '0);
      last     <= 1'b0;
    end else if (acc) begin
      op       <= operand;
      cnt      <= '0;
      seq      <= '0;
      bitValid <= 1'b0;
      last     <= 1'b0;
    end else if (emit) begin
      bitValid <= 1'b1;
      randOut  <= seq;
      bitOut   <= (op > seq);
      last     <= &cnt;
      if (!(&cnt)) begin
        cnt <= cnt + INWD'(1);
        seq <= seq ^ dir;
      end
    end else begin
      bitValid <= 1'b0;
      last     <= 1'b0;
    end
  end

`ifdef SNG_ONES_CNT_EN
  // Ones tally of the current stream; kept after the stream ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onesCnt <= '0;
    end else if (acc) begin
      onesCnt <= {{INWD{1'b0}}, emit0 && (operand != '0)};
    end else if (emit && (op > seq)) begin
      onesCnt <= onesCnt + (INWD+1)'(1);
    end
  end
`endif

endmodule

// File: doc/sobol_sng_ctrl.md
# sobol_sng_ctrl

Sequencer for a dimension-1 Sobol generator that turns one INWD-bit binary operand into a full-period stochastic bitstream of 2^INWD bits. It contains the counter, least-significant-zero index and direction-vector XOR datapath, and a small FSM that starts, stalls, aborts and terminates streams. It sits between a binary operand source and the stochastic compute units (multipliers, adders) that consume the bitstream.

## Interface
- INWD, 8: operand, random-number and counter width (3..10).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new stream; accepted per Operation.
- operand  in  INWD  unsigned value to encode, sampled on accepted start.
- hold  in  1  stall; freezes generator and output.
- abort  in  1  terminate current stream without completion.
- busy  out  1  stream in progress (state RUN).
- bitValid  out  1  bitOut/randOut valid this cycle.
- bitOut  out  1  stochastic bit = (operand_latched > randOut).
- randOut  out  INWD  Sobol value used for this bit.
- last  out  1  qualifies the final (2^INWD-th) bit of a stream.
- onesCnt  out  INWD+1  ones emitted in current/last stream (only with SNG_ONES_CNT_EN).

## Operation
- States: IDLE, RUN. Reset -> IDLE.
- Start accepted when state IDLE, or when bitValid&&last is registered this cycle (back-to-back chaining). Start is ignored at any other time in RUN.
- On accept: latch operand, clear cnt and seq to 0, state RUN.
- Generator: seq_{n+1} = seq_n ^ dirVec[k], where k = index of least significant zero of cnt, dirVec[k] = 1 << (INWD-1-k); cnt increments by 1. With cnt all ones (final step), no advance is needed; the stream ends.
- In RUN, per non-hold cycle: register bitValid=1, randOut=seq, bitOut=(op>seq) unsigned INWD-bit compare, last=(cnt==2^INWD-1); then advance cnt/seq.
- hold=1 in RUN: bitValid=0 next cycle; cnt, seq, op frozen; randOut/bitOut hold previous values. hold in IDLE: no effect.
- After the cycle producing last, state returns to IDLE unless a chained start is accepted.
- abort=1 in RUN: state IDLE next cycle, bitValid=0, last never asserted; abort wins over hold and over chained start. abort in IDLE: ignored; start and abort together in IDLE -> start accepted.
- Full period: the 2^INWD values of randOut are a permutation of 0..2^INWD-1, so the ones count equals operand exactly; operand 0 -> all zeros, operand 2^INWD-1 -> exactly one zero.

## Timing
- Reset values: busy=0, bitValid=0, bitOut=0, randOut=0, last=0, onesCnt=0; internal cnt=0, seq=0, op=0.
- Start accepted at edge T: busy=1 and first bit (randOut=0) valid after T+1; with no hold, bit k is valid at T+1+k, last at T+2^INWD, busy=0 after T+2^INWD+1.
- Chained start in the last cycle: the first bit of the new stream is valid in the next cycle with no gap; busy stays 1.
- Each hold cycle delays all remaining bits by exactly one cycle.
- Asynchronous reset mid-stream: immediate return to reset values; no last.

## Configuration
- SNG_ONES_CNT_EN: when defined, onesCnt port exists; cleared on accepted start, incremented on each valid bit with bitOut=1, holds its final value in IDLE, cleared by reset. Without it, the port and counter are absent; all other behaviour is identical.

## Test plan
- INWD=4, operand=5, start pulse, no hold -> randOut 0,8,12,4,6,14,10,2,3,11,15,7,5,13,9,1 on 16 consecutive cycles; bitOut=1 at bits 0,3,7,8,15 only; last on bit 15; onesCnt=5.
- INWD=4, operand=0 then operand=15 chained via start in the last cycle -> 32 contiguous valid bits, no gap; ones 0 then 15; busy high throughout.
- INWD=4, operand=9, hold high for 3 cycles after bit 4 -> bitValid low 3 cycles, bit 5 randOut=14 after the stall; total 16 valid bits, 9 ones.
- abort at bit 6 -> bitValid=0 next cycle, busy=0, no last; a new start gives randOut=0 first.
- start asserted at bit 3 of a running stream -> ignored; stream unchanged, operand not relatched.
- rst_n low at bit 10 -> all outputs 0 immediately; after release, IDLE until start.
